// File: rtl/sel_hold_pkg.sv
// Shared types and mode constants for the select-and-hold multiplexer.
package sel_hold_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int MODE_PRIORITY = 0;
  localparam int MODE_STRICT   = 1;

endpackage

// File: rtl/sel_decode.sv
// Combinational select decoder: maps a select vector to a channel index and
// a legality flag (exactly one-hot in strict mode, any bit set in priority mode).
module sel_decode
  import sel_hold_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int STRICT = 1,
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic [NCH-1:0]   sel,
  output logic [IDX_W-1:0] idx,
  output logic             legal
);

  logic [31:0] cnt_s;
  logic        found_s;

  // Lowest set bit gives the index; the population count decides legality.
  always_comb begin
    idx     = '0;
    found_s = 1'b0;
    cnt_s   = 32'd0;
    for (int k = 0; k < NCH; k++) begin
      cnt_s = cnt_s + {31'd0, sel[k]};
      if (sel[k] && !found_s) begin
        idx     = IDX_W'(k);
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    if (STRICT == MODE_STRICT) begin
      legal = (cnt_s == 32'd1);
    end else begin
      legal = (cnt_s != 32'd0);
    end
  end

endmodule

// File: rtl/sel_hold_mux.sv
// Select-and-hold multiplexer with a one-entry valid/ready output stage,
// illegal-select error reporting and a saturating staleness counter.
module sel_hold_mux
  import sel_hold_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter int NCH       = 2,
  parameter int STRICT    = 1,
  parameter int STALE_MAX = 15,
  localparam int HW       = $clog2(STALE_MAX + 1),
  localparam int IDX_W    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NCH*WIDTH-1:0] data_in,
  input  logic [NCH-1:0]       sel,
  input  logic                 sel_valid,
  output logic                 sel_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 sel_err,
  output logic [7:0]           err_cnt,
  output logic [HW-1:0]        hold_cnt,
  output logic                 stale
);

  state_t           state_r;
  state_t           state_next_s;
  logic [WIDTH-1:0] data_r;
  logic             err_r;
  logic [7:0]       err_cnt_r;
  logic [HW-1:0]    hold_r;
  logic [HW-1:0]    hold_next_s;
  logic             stale_r;
  logic [IDX_W-1:0] idx_s;
  logic             legal_s;
  logic             accept_s;
  logic             legal_accept_s;
  logic             illegal_accept_s;
  logic [WIDTH-1:0] sel_data_s;

  sel_decode #(
    .NCH    (NCH),
    .STRICT (STRICT)
  ) u_sel_decode (
    .sel   (sel),
    .idx   (idx_s),
    .legal (legal_s)
  );

  assign sel_ready        = (state_r == EMPTY) || out_ready;
  assign accept_s         = sel_valid && sel_ready;
  assign legal_accept_s   = accept_s && legal_s;
  assign illegal_accept_s = accept_s && !legal_s;
  assign sel_data_s       = data_in[int'(idx_s)*WIDTH +: WIDTH];

  // Output-stage state register; FULL is exactly out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: fill on a legal accept, drain on a pop that is not refilled.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (legal_accept_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (out_ready && !legal_accept_s) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: begin
        state_next_s = EMPTY;
      end
    endcase
  end

  // Data hold register: only a legal accept replaces the value.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
    end else if (legal_accept_s) begin
      data_r <= sel_data_s;
    end else begin
      data_r <= data_r;
    end
  end

  // Error pulse and saturating error counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r     <= 1'b0;
      err_cnt_r <= 8'd0;
    end else begin
      err_r <= illegal_accept_s;
      if (illegal_accept_s && (err_cnt_r != 8'd255)) begin
        err_cnt_r <= err_cnt_r + 8'd1;
      end else begin
        err_cnt_r <= err_cnt_r;
      end
    end
  end

  // Staleness counter advance, saturating at STALE_MAX.
  always_comb begin
    hold_next_s = hold_r;
    if (legal_accept_s) begin
      hold_next_s = '0;
    end else if (hold_r == HW'(STALE_MAX)) begin
      hold_next_s = hold_r;
    end else begin
      hold_next_s = hold_r + HW'(1);
    end
  end

  // stale is registered alongside hold_cnt so it never sees input timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r  <= '0;
      stale_r <= 1'b0;
    end else begin
      hold_r  <= hold_next_s;
      stale_r <= (hold_next_s == HW'(STALE_MAX));
    end
  end

  assign data_out  = data_r;
  assign out_valid = (state_r == FULL);
  assign sel_err   = err_r;
  assign err_cnt   = err_cnt_r;
  assign hold_cnt  = hold_r;
  assign stale     = stale_r;

endmodule

// File: tb/tb_sel_hold_mux.sv
// Self-checking bench: strict and priority instances driven in lockstep and
// compared against a behavioural model, fixed vectors and corner sequences.
module tb_sel_hold_mux;

  logic        clk;
  logic        rst;
  logic [15:0] data_in;
  logic [3:0]  sel;
  logic        sel_valid;
  logic        out_ready;

  logic        s_ready, p_ready;
  logic [3:0]  s_data, p_data;
  logic        s_valid, p_valid;
  logic        s_err, p_err;
  logic [7:0]  s_ecnt, p_ecnt;
  logic [1:0]  s_hold, p_hold;
  logic        s_stale, p_stale;

  int checks = 0;
  int errors = 0;

  // model state, index 1 = strict, index 0 = priority
  int m_valid [2];
  int m_data  [2];
  int m_err   [2];
  int m_ecnt  [2];
  int m_hold  [2];

  sel_hold_mux #(.WIDTH(4), .NCH(4), .STRICT(1), .STALE_MAX(3)) u_strict (
    .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(s_ready), .data_out(s_data), .out_valid(s_valid), .out_ready(out_ready),
    .sel_err(s_err), .err_cnt(s_ecnt), .hold_cnt(s_hold), .stale(s_stale)
  );

  sel_hold_mux #(.WIDTH(4), .NCH(4), .STRICT(0), .STALE_MAX(3)) u_prio (
    .clk(clk), .rst(rst), .data_in(data_in), .sel(sel), .sel_valid(sel_valid),
    .sel_ready(p_ready), .data_out(p_data), .out_valid(p_valid), .out_ready(out_ready),
    .sel_err(p_err), .err_cnt(p_ecnt), .hold_cnt(p_hold), .stale(p_stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [3:0]  s;
    logic [15:0] d;
    logic        o;
    logic        s_valid;
    logic [3:0]  s_data;
    logic        s_err;
    logic [7:0]  s_ecnt;
    logic [1:0]  s_hold;
    logic        p_valid;
    logic [3:0]  p_data;
    logic        p_err;
    logic [7:0]  p_ecnt;
    logic [1:0]  p_hold;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic model_update(input logic r, input logic v, input logic [3:0] s,
                              input logic [15:0] d, input logic o);
    for (int m = 0; m < 2; m++) begin
      int  pc;
      int  idx;
      bit  legal;
      bit  ready;
      bit  acc;
      pc  = $countones(s);
      idx = 0;
      for (int k = 3; k >= 0; k--) begin
        if (s[k]) idx = k;
      end
      legal = (m == 1) ? (pc == 1) : (pc != 0);
      ready = (m_valid[m] == 0) || o;
      acc   = v && ready;
      if (r) begin
        m_valid[m] = 0; m_data[m] = 0; m_err[m] = 0; m_ecnt[m] = 0; m_hold[m] = 0;
      end else begin
        m_err[m] = (acc && !legal) ? 1 : 0;
        if (acc && !legal && m_ecnt[m] < 255) m_ecnt[m] = m_ecnt[m] + 1;
        if (acc && legal) begin
          m_data[m]  = int'(d[idx*4 +: 4]);
          m_valid[m] = 1;
          m_hold[m]  = 0;
        end else begin
          if (m_valid[m] == 1 && o) m_valid[m] = 0;
          m_hold[m] = (m_hold[m] + 1 > 3) ? 3 : m_hold[m] + 1;
        end
      end
    end
  endtask

  // Drive one cycle of stimulus, then compare both instances with the model.
  task automatic step(input logic r, input logic v, input logic [3:0] s,
                      input logic [15:0] d, input logic o);
    rst = r; sel_valid = v; sel = s; data_in = d; out_ready = o;
    #1;
    if (!r) begin
      chk("S.sel_ready", int'(s_ready), (m_valid[1] == 0 || o) ? 1 : 0);
      chk("P.sel_ready", int'(p_ready), (m_valid[0] == 0 || o) ? 1 : 0);
    end
    model_update(r, v, s, d, o);
    @(posedge clk);
    #1;
    chk("S.data",  int'(s_data),  m_data[1]);
    chk("S.valid", int'(s_valid), m_valid[1]);
    chk("S.err",   int'(s_err),   m_err[1]);
    chk("S.ecnt",  int'(s_ecnt),  m_ecnt[1]);
    chk("S.hold",  int'(s_hold),  m_hold[1]);
    chk("S.stale", int'(s_stale), (m_hold[1] == 3) ? 1 : 0);
    chk("P.data",  int'(p_data),  m_data[0]);
    chk("P.valid", int'(p_valid), m_valid[0]);
    chk("P.err",   int'(p_err),   m_err[0]);
    chk("P.ecnt",  int'(p_ecnt),  m_ecnt[0]);
    chk("P.hold",  int'(p_hold),  m_hold[0]);
    chk("P.stale", int'(p_stale), (m_hold[0] == 3) ? 1 : 0);
  endtask

  initial begin
    logic [1:0] hold_exp [5];
    logic       stale_exp [5];
    hold_exp[0] = 2'd1; hold_exp[1] = 2'd2; hold_exp[2] = 2'd3; hold_exp[3] = 2'd3; hold_exp[4] = 2'd3;
    stale_exp[0] = 1'b0; stale_exp[1] = 1'b0; stale_exp[2] = 1'b1; stale_exp[3] = 1'b1; stale_exp[4] = 1'b1;

    //            v     sel      din       o    | strict: vld data err ecnt hold | prio: vld data err ecnt hold
    tbl[0] = '{1'b1, 4'b0100, 16'h3A21, 1'b0, 1'b1, 4'hA, 1'b0, 8'd0, 2'd0, 1'b1, 4'hA, 1'b0, 8'd0, 2'd0};
    tbl[1] = '{1'b1, 4'b0110, 16'h3A21, 1'b1, 1'b0, 4'hA, 1'b1, 8'd1, 2'd1, 1'b1, 4'h2, 1'b0, 8'd0, 2'd0};
    tbl[2] = '{1'b0, 4'b0000, 16'h3A21, 1'b0, 1'b0, 4'hA, 1'b0, 8'd1, 2'd2, 1'b1, 4'h2, 1'b0, 8'd0, 2'd1};
    tbl[3] = '{1'b1, 4'b1000, 16'h5A21, 1'b1, 1'b1, 4'h5, 1'b0, 8'd1, 2'd0, 1'b1, 4'h5, 1'b0, 8'd0, 2'd0};
    tbl[4] = '{1'b1, 4'b0000, 16'h5A21, 1'b0, 1'b1, 4'h5, 1'b0, 8'd1, 2'd1, 1'b1, 4'h5, 1'b0, 8'd0, 2'd1};
    tbl[5] = '{1'b1, 4'b0001, 16'h5A21, 1'b0, 1'b1, 4'h5, 1'b0, 8'd1, 2'd2, 1'b1, 4'h5, 1'b0, 8'd0, 2'd2};
    tbl[6] = '{1'b0, 4'b0000, 16'h5A21, 1'b1, 1'b0, 4'h5, 1'b0, 8'd1, 2'd3, 1'b0, 4'h5, 1'b0, 8'd0, 2'd3};
    tbl[7] = '{1'b1, 4'b0000, 16'h5A21, 1'b0, 1'b0, 4'h5, 1'b1, 8'd2, 2'd3, 1'b0, 4'h5, 1'b1, 8'd1, 2'd3};

    for (int m = 0; m < 2; m++) begin
      m_valid[m] = 0; m_data[m] = 0; m_err[m] = 0; m_ecnt[m] = 0; m_hold[m] = 0;
    end
    rst = 1'b1; sel_valid = 1'b0; sel = 4'b0000; data_in = 16'h0000; out_ready = 1'b0;

    // reset state
    step(1'b1, 1'b0, 4'b0000, 16'h0000, 1'b0);
    chk("reset.data", int'(s_data), 0);
    chk("reset.valid", int'(s_valid), 0);
    chk("reset.stale", int'(s_stale), 0);

    // fixed vectors
    for (int i = 0; i < 8; i++) begin
      step(1'b0, tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].o);
      chk($sformatf("tbl%0d.S.valid", i), int'(s_valid), int'(tbl[i].s_valid));
      chk($sformatf("tbl%0d.S.data", i),  int'(s_data),  int'(tbl[i].s_data));
      chk($sformatf("tbl%0d.S.err", i),   int'(s_err),   int'(tbl[i].s_err));
      chk($sformatf("tbl%0d.S.ecnt", i),  int'(s_ecnt),  int'(tbl[i].s_ecnt));
      chk($sformatf("tbl%0d.S.hold", i),  int'(s_hold),  int'(tbl[i].s_hold));
      chk($sformatf("tbl%0d.P.valid", i), int'(p_valid), int'(tbl[i].p_valid));
      chk($sformatf("tbl%0d.P.data", i),  int'(p_data),  int'(tbl[i].p_data));
      chk($sformatf("tbl%0d.P.err", i),   int'(p_err),   int'(tbl[i].p_err));
      chk($sformatf("tbl%0d.P.ecnt", i),  int'(p_ecnt),  int'(tbl[i].p_ecnt));
      chk($sformatf("tbl%0d.P.hold", i),  int'(p_hold),  int'(tbl[i].p_hold));
      if (i == 0) begin
        chk("tbl0.S.sel_ready_full", int'(s_ready), 0);
        chk("tbl0.P.sel_ready_full", int'(p_ready), 0);
      end
    end

    // staleness after an update
    step(1'b0, 1'b1, 4'b0001, 16'h1237, 1'b1);
    chk("upd.S.hold", int'(s_hold), 0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 4'b0000, 16'h1237, 1'b0);
      chk($sformatf("idle%0d.S.hold", i), int'(s_hold), int'(hold_exp[i]));
      chk($sformatf("idle%0d.S.stale", i), int'(s_stale), int'(stale_exp[i]));
      chk($sformatf("idle%0d.P.stale", i), int'(p_stale), int'(stale_exp[i]));
    end

    // error counter saturation
    for (int i = 0; i < 300; i++) begin
      step(1'b0, 1'b1, 4'b0000, 16'($urandom), 1'b1);
    end
    chk("sat.S.ecnt", int'(s_ecnt), 255);
    chk("sat.P.ecnt", int'(p_ecnt), 255);

    // reset wins over a simultaneous accept and pop
    step(1'b0, 1'b1, 4'b0010, 16'hC3B1, 1'b1);
    chk("pre_rst.S.valid", int'(s_valid), 1);
    step(1'b1, 1'b1, 4'b0010, 16'hC3B1, 1'b1);
    chk("rst.S.valid", int'(s_valid), 0);
    chk("rst.S.data",  int'(s_data), 0);
    chk("rst.S.ecnt",  int'(s_ecnt), 0);
    chk("rst.P.valid", int'(p_valid), 0);
    chk("rst.P.data",  int'(p_data), 0);
    chk("rst.P.hold",  int'(p_hold), 0);
    step(1'b0, 1'b1, 4'b0010, 16'hC3B1, 1'b0);
    chk("post_rst.S.data", int'(s_data), 11);

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic [3:0]  s;
      r = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 1) == 1) s = 4'(1 << $urandom_range(0, 3));
      else s = 4'($urandom);
      step(r, 1'($urandom), s, 16'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sel_hold_mux.md
SEL_HOLD_MUX -- requirements
Module: sel_hold_mux

Interface
REQ-001 Parameter WIDTH, default 4, data width per channel (>=1).
REQ-002 Parameter NCH, default 2, number of input channels (>=2).
REQ-003 Parameter STRICT, default 1, selection mode: 1 = exactly one-hot required; 0 = lowest-index set bit wins.
REQ-004 Parameter STALE_MAX, default 15, saturation value of the hold counter (>=1).
REQ-005 Port clk  input  1  single clock, all state on rising edge.
REQ-006 Port rst  input  1  reset: synchronous, active-high.
REQ-007 Port data_in  input  NCH*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 Port sel  input  NCH  channel select vector.
REQ-009 Port sel_valid  input  1  sel and data_in are presented.
REQ-010 Port sel_ready  output  1  block can accept a selection this cycle.
REQ-011 Port data_out  output  WIDTH  registered selected or held value.
REQ-012 Port out_valid  output  1  data_out holds an unconsumed update.
REQ-013 Port out_ready  input  1  downstream consumes data_out.
REQ-014 Port sel_err  output  1  one-cycle pulse on an accepted illegal selection.
REQ-015 Port err_cnt  output  8  count of illegal selections, saturates at 255.
REQ-016 Port hold_cnt  output  $clog2(STALE_MAX+1)  cycles since the last legal update, saturating.
REQ-017 Port stale  output  1  high while hold_cnt == STALE_MAX.

Function
REQ-018 Accept occurs when sel_valid && sel_ready are both high in a cycle.
REQ-019 sel_ready SHALL be combinational: !out_valid || out_ready.
REQ-020 Legal selection: STRICT=1, popcount(sel)==1; STRICT=0, sel != 0. sel == 0 is illegal in both modes.
REQ-021 On a legal accept: data_out <= selected channel on the next edge, out_valid <= 1, hold_cnt <= 0; latency 1 cycle.
REQ-022 On an illegal accept: data_out and out_valid keep their values (except as popped, REQ-024), sel_err = 1 for exactly the next cycle, err_cnt += 1 (saturating).
REQ-023 With no legal accept, data_out SHALL hold its value indefinitely. The hold is an explicit register, never a latch or an incomplete assignment.
REQ-024 Pop: out_valid && out_ready with no legal accept -> out_valid <= 0; data_out unchanged.
REQ-025 Simultaneous pop and legal accept -> out_valid stays 1, data_out takes the new value.
REQ-026 Two-state FSM EMPTY/FULL mirrors out_valid. EMPTY->FULL on a legal accept. FULL->EMPTY on a pop without a legal accept. Otherwise the state is held.
REQ-027 hold_cnt increments by 1 each cycle without a legal accept and saturates at STALE_MAX. A legal accept clears it regardless of the prior value.
REQ-028 stale is derived from registered hold_cnt; it has no combinational path from inputs.
REQ-029 sel_valid while sel_ready is low SHALL be ignored: no state change, no error.

Reset
REQ-030 While rst is high at an edge: data_out = 0, out_valid = 0, state = EMPTY, sel_err = 0, err_cnt = 0, hold_cnt = 0, stale = 0.
REQ-031 Reset SHALL override any simultaneous accept or pop. The first accept is possible in the cycle after rst deasserts.

Structure
REQ-032 Package sel_hold_pkg SHALL hold the FSM state enum (EMPTY, FULL) and the mode constants MODE_PRIORITY = 0 and MODE_STRICT = 1.
REQ-033 Sub-module sel_decode (combinational) SHALL map sel to a channel index plus a legal flag per STRICT. sel_hold_mux instantiates it once.

Verification
REQ-034 Bench SHALL use WIDTH=4, NCH=4, STALE_MAX=3, and run the scenarios in both STRICT values where noted:
- Reset, then sel=4'b0100, data_in ch2=4'hA, out_ready=0 -> next cycle data_out=4'hA, out_valid=1, sel_ready=0, hold_cnt=0.
- STRICT=1, sel=4'b0110 accepted -> sel_err pulses once, err_cnt=1, data_out unchanged. Same stimulus with STRICT=0 -> data_out = ch1, no error.
- out_valid=1, out_ready=1 with a legal accept of ch3=4'h5 in the same cycle -> out_valid stays 1, data_out=4'h5.
- No accept for 5 cycles after an update -> hold_cnt goes 1, 2, 3, 3, 3; stale high from the third cycle.
- sel=4'b0000 accepted 300 times -> err_cnt saturates at 255.
- rst asserted in the same cycle as a legal accept and a pop -> all outputs at their reset values next cycle.
